jt12_mux_rx: RTL and testbench
==============================

JT12_MUX_RX -- requirements
Module: jt12_mux_rx

Interface
REQ-001 Parameter CHANNELS, default 6, number of time-multiplexed channel slots per frame (legal 2..6).
REQ-002 rst  input  1  asynchronous reset, active-high.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 clk_en  input  1  clock enable; no state changes except reset when low.
REQ-005 mux_left  input  9  signed two's-complement left sample for the current slot.
REQ-006 mux_right  input  9  signed two's-complement right sample for the current slot.
REQ-007 mux_sample  input  1  slot strobe; mux_left/mux_right valid when high with clk_en.
REQ-008 frame_sync  input  1  marks the strobed slot as channel 0; ignored unless mux_sample is high.
REQ-009 ch_sel  input  3  channel index for per-channel readback.
REQ-010 left  output  12  signed frame sum, left.
REQ-011 right  output  12  signed frame sum, right.
REQ-012 sample  output  1  new left/right frame available.
REQ-013 ch_left  output  9  last captured left value of channel ch_sel.
REQ-014 ch_right  output  9  last captured right value of channel ch_sel.
REQ-015 locked  output  1  high when the frame FSM is not in HUNT.
REQ-016 sync_err  output  1  one-enable-period pulse on any framing violation.

Function
REQ-017 A "strobe" is an edge with clk_en=1 and mux_sample=1; all behaviour below occurs only on clk_en=1 edges.
REQ-018 FSM states: HUNT, RUN, DONE; slot counter 0..CHANNELS-1.
REQ-019 Any state, strobe with frame_sync=1: capture slot 0, acc_l/acc_r <= sign-extended 9->12-bit inputs, slot <= 1, state RUN.
REQ-020 HUNT, strobe with frame_sync=0: sample discarded, stay HUNT, no sync_err.
REQ-021 RUN, strobe with frame_sync=0: capture into channel [slot], acc += sign-extended input, slot <= slot+1.
REQ-022 RUN, strobe that is slot CHANNELS-1: left/right <= acc + this input (12-bit, no saturation; range cannot overflow), sample <= 1, state DONE.
REQ-023 sample SHALL be high for exactly one clk_en-qualified period, cleared on the next clk_en edge.
REQ-024 RUN, frame_sync strobe with slot < CHANNELS: sync_err <= 1, partial frame discarded (left/right unchanged, no sample), then REQ-019 applies.
REQ-025 DONE, strobe with frame_sync=0: sync_err <= 1, sample discarded, state HUNT.
REQ-026 DONE, frame_sync strobe: no error, REQ-019 applies.
REQ-027 sync_err SHALL clear on the next clk_en edge unless a new violation occurs.
REQ-028 Per-channel capture registers (9-bit L/R per channel) update only on accepted strobes (RUN or frame_sync), never in HUNT.
REQ-029 ch_left/ch_right combinationally select capture register ch_sel; ch_sel >= CHANNELS returns 0.
REQ-030 Zero-latency rule: a strobe's value appears on ch_left/ch_right after the same edge; frame sum appears on left/right after the last-slot edge, together with sample.

Reset
REQ-031 While rst high: state HUNT, slot 0, acc 0, all capture registers 0, left=0, right=0, sample=0, sync_err=0, locked=0.
REQ-032 rst asserted mid-frame SHALL discard the partial frame; after release, outputs update only after a new frame_sync.

Verification
REQ-033 Reset release, 6 strobes values L=1..6, R=-1..-6, frame_sync on first -> after 6th strobe left=21, right=-21, sample one enable period, locked=1.
REQ-034 6 strobes all L=+255 (0x0FF), R=-256 (0x100) with sync -> left=1530, right=-1536, no sync_err.
REQ-035 3 strobes after sync, then frame_sync strobe -> sync_err pulse, left/right keep previous frame, next full frame sums correctly.
REQ-036 Full frame, then 7th strobe without frame_sync -> sync_err pulse, locked=0, further non-sync strobes ignored until frame_sync.
REQ-037 clk_en toggling 1-of-4 with mux_sample held high between enables -> only enabled edges counted; sample width equals one enable period.
REQ-038 Async rst pulse between edges during slot 3 -> all outputs 0 immediately; ch_sel=2 readback 0; next synced frame reported correctly.

Source files
------------

// File: rtl/jt12_mux_rx.sv
// Demultiplexes time-slotted 9-bit stereo samples into per-channel capture
// registers and produces a 12-bit signed sum once every frame is complete.
module jt12_mux_rx #(
  parameter int CHANNELS = 6
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        clk_en,
  input  logic [8:0]  mux_left,
  input  logic [8:0]  mux_right,
  input  logic        mux_sample,
  input  logic        frame_sync,
  input  logic [2:0]  ch_sel,
  output logic [11:0] left,
  output logic [11:0] right,
  output logic        sample,
  output logic [8:0]  ch_left,
  output logic [8:0]  ch_right,
  output logic        locked,
  output logic        sync_err
);

  typedef enum logic [1:0] {
    HUNT,
    RUN,
    DONE
  } state_t;

  localparam logic [2:0] LAST_SLOT = 3'(CHANNELS - 1);

  state_t      state;
  logic [2:0]  slot;
  logic [11:0] acc_l;
  logic [11:0] acc_r;
  logic [8:0]  cap_l [CHANNELS];
  logic [8:0]  cap_r [CHANNELS];
  logic [11:0] ext_l;
  logic [11:0] ext_r;

  assign ext_l  = {{3{mux_left[8]}}, mux_left};
  assign ext_r  = {{3{mux_right[8]}}, mux_right};
  assign locked = (state != HUNT);

  // A frame_sync strobe always restarts the frame; it is only a violation
  // when it cuts a frame short (RUN), not when it follows a finished one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HUNT;
      slot     <= '0;
      acc_l    <= '0;
      acc_r    <= '0;
      left     <= '0;
      right    <= '0;
      sample   <= 1'b0;
      sync_err <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cap_l[i] <= '0;
        cap_r[i] <= '0;
      end
    end else if (clk_en) begin
      sample   <= 1'b0;
      sync_err <= 1'b0;
      if (mux_sample) begin
        if (frame_sync) begin
          if (state == RUN) sync_err <= 1'b1;
          cap_l[0] <= mux_left;
          cap_r[0] <= mux_right;
          acc_l    <= ext_l;
          acc_r    <= ext_r;
          slot     <= 3'd1;
          state    <= RUN;
        end else begin
          case (state)
            RUN: begin
              cap_l[slot] <= mux_left;
              cap_r[slot] <= mux_right;
              if (slot == LAST_SLOT) begin
                left   <= acc_l + ext_l;
                right  <= acc_r + ext_r;
                sample <= 1'b1;
                slot   <= '0;
                state  <= DONE;
              end else begin
                acc_l <= acc_l + ext_l;
                acc_r <= acc_r + ext_r;
                slot  <= slot + 3'd1;
              end
            end
            DONE: begin
              sync_err <= 1'b1;
              slot     <= '0;
              state    <= HUNT;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Out-of-range channel indices read back as silence.
  always_comb begin
    ch_left  = '0;
    ch_right = '0;
    if (32'(ch_sel) < CHANNELS) begin
      ch_left  = cap_l[ch_sel];
      ch_right = cap_r[ch_sel];
    end
  end

endmodule

// File: tb/tb_jt12_mux_rx.sv
// Randomized and directed bench for jt12_mux_rx, checked against a
// frame-level reference model built on queues of accepted slot samples.
module tb_jt12_mux_rx;

  localparam int CHANNELS = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic [8:0]  mux_left = '0;
  logic [8:0]  mux_right = '0;
  logic        mux_sample = 1'b0;
  logic        frame_sync = 1'b0;
  logic [2:0]  ch_sel = '0;
  logic [11:0] left;
  logic [11:0] right;
  logic        sample;
  logic [8:0]  ch_left;
  logic [8:0]  ch_right;
  logic        locked;
  logic        sync_err;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: the frame in progress is just a list of accepted samples.
  bit          hunting;
  bit          frameDone;
  int          qL[$];
  int          qR[$];
  logic [8:0]  capL[CHANNELS];
  logic [8:0]  capR[CHANNELS];
  logic [11:0] expLeft;
  logic [11:0] expRight;
  logic        expSample;
  logic        expErr;

  jt12_mux_rx #(.CHANNELS(CHANNELS)) dut (
    .rst(rst), .clk(clk), .clk_en(clk_en),
    .mux_left(mux_left), .mux_right(mux_right),
    .mux_sample(mux_sample), .frame_sync(frame_sync), .ch_sel(ch_sel),
    .left(left), .right(right), .sample(sample),
    .ch_left(ch_left), .ch_right(ch_right),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    hunting   = 1'b1;
    frameDone = 1'b0;
    qL.delete();
    qR.delete();
    for (int i = 0; i < CHANNELS; i++) begin
      capL[i] = '0;
      capR[i] = '0;
    end
    expLeft   = '0;
    expRight  = '0;
    expSample = 1'b0;
    expErr    = 1'b0;
  endtask

  // Applies the effect of one rising edge using the inputs present at that edge.
  task automatic modelEdge();
    int sumL;
    int sumR;
    if (!clk_en) return;
    expSample = 1'b0;
    expErr    = 1'b0;
    if (!mux_sample) return;
    if (frame_sync) begin
      if (!hunting && !frameDone) expErr = 1'b1;
      qL.delete();
      qR.delete();
      qL.push_back($signed(mux_left));
      qR.push_back($signed(mux_right));
      capL[0]   = mux_left;
      capR[0]   = mux_right;
      hunting   = 1'b0;
      frameDone = 1'b0;
    end else if (hunting) begin
      // discarded
    end else if (frameDone) begin
      expErr    = 1'b1;
      hunting   = 1'b1;
      frameDone = 1'b0;
      qL.delete();
      qR.delete();
    end else begin
      capL[qL.size()] = mux_left;
      capR[qR.size()] = mux_right;
      qL.push_back($signed(mux_left));
      qR.push_back($signed(mux_right));
      if (qL.size() == CHANNELS) begin
        sumL = 0;
        sumR = 0;
        foreach (qL[i]) sumL += qL[i];
        foreach (qR[i]) sumR += qR[i];
        expLeft   = 12'(sumL);
        expRight  = 12'(sumR);
        expSample = 1'b1;
        frameDone = 1'b1;
      end
    end
  endtask

  task automatic checkAll();
    logic [8:0] eL;
    logic [8:0] eR;
    ch_sel = 3'($urandom_range(0, 7));
    #1;
    eL = (int'(ch_sel) < CHANNELS) ? capL[ch_sel] : 9'd0;
    eR = (int'(ch_sel) < CHANNELS) ? capR[ch_sel] : 9'd0;
    checkOutput("left", left, expLeft);
    checkOutput("right", right, expRight);
    checkOutput("sample", {11'd0, sample}, {11'd0, expSample});
    checkOutput("sync_err", {11'd0, sync_err}, {11'd0, expErr});
    checkOutput("locked", {11'd0, locked}, {11'd0, !hunting});
    checkOutput("ch_left", {3'd0, ch_left}, {3'd0, eL});
    checkOutput("ch_right", {3'd0, ch_right}, {3'd0, eR});
  endtask

  task automatic applyStimulus(input logic en, input logic ms, input logic fs,
                               input logic [8:0] l, input logic [8:0] r);
    clk_en     = en;
    mux_sample = ms;
    frame_sync = fs;
    mux_left   = l;
    mux_right  = r;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  // Pulses reset between edges and checks the outputs clear immediately.
  task automatic pulseReset();
    rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    rst = 1'b0;
  endtask

  task automatic countedFrame(input int first);
    for (int i = 0; i < CHANNELS; i++)
      applyStimulus(1'b1, 1'b1, i == 0, 9'(first + i), 9'(-(first + i)));
  endtask

  initial begin
    modelReset();
    #12;
    checkAll();
    rst = 1'b0;

    // Ascending values, frame_sync on the first slot.
    for (int i = 0; i < CHANNELS; i++)
      applyStimulus(1'b1, 1'b1, i == 0, 9'(i + 1), 9'(-(i + 1)));
    checkOutput("req33_left", left, 12'd21);
    checkOutput("req33_right", right, 12'hFEB);
    checkOutput("req33_sample", {11'd0, sample}, 12'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'd0, 9'd0);
    checkOutput("req33_sample_clr", {11'd0, sample}, 12'd0);

    // Extreme values: largest positive and most negative inputs.
    for (int i = 0; i < CHANNELS; i++)
      applyStimulus(1'b1, 1'b1, i == 0, 9'h0FF, 9'h100);
    checkOutput("req34_left", left, 12'd1530);
    checkOutput("req34_right", right, 12'hA00);

    // Frame cut short by an early frame_sync, then a clean frame.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, i == 0, 9'd7, 9'd9);
    applyStimulus(1'b1, 1'b1, 1'b1, 9'd10, 9'd20);
    checkOutput("req35_err", {11'd0, sync_err}, 12'd1);
    checkOutput("req35_keep", left, 12'd1530);
    for (int i = 1; i < CHANNELS; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 9'd10, 9'd20);
    checkOutput("req35_left", left, 12'd60);

    // Overlong frame drops lock until the next frame_sync.
    countedFrame(3);
    applyStimulus(1'b1, 1'b1, 1'b0, 9'd1, 9'd1);
    checkOutput("req36_locked", {11'd0, locked}, 12'd0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 9'($urandom), 9'($urandom));

    // Enable active one edge in four while the strobe stays high.
    for (int i = 0; i < 4 * CHANNELS + 4; i++)
      applyStimulus(i % 4 == 0, 1'b1, i == 0, 9'(i), 9'(2 * i));

    // Asynchronous reset in the middle of a frame.
    countedFrame(5);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, i == 0, 9'd33, 9'd44);
    pulseReset();
    ch_sel = 3'd2;
    #1;
    checkOutput("req38_ch2", {3'd0, ch_left}, 12'd0);
    checkOutput("req38_left", left, 12'd0);
    countedFrame(8);

    // Random traffic with occasional reset pulses.
    for (int n = 0; n < 1500; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 9) == 0, 9'($urandom), 9'($urandom));
      if ($urandom_range(0, 299) == 0) pulseReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
